load_store_unit: RTL

- Sits between the execute stage and data_memory.
- Converts RV32I byte/halfword/word load-store requests into word-granular data_memory accesses.
- Performs alignment checks, sign/zero extension and read-modify-write for SB/SH.
- Returns one response per request over a valid/ready handshake.

---
 rtl/load_store_unit.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Turns RV32I byte/halfword/word loads and stores into word-granular
//   data_memory accesses. It checks alignment, sign- or zero-extends loads,
//   and does a read-modify-write for SB/SH. Each request gets exactly one
//   response over a valid/ready handshake.
//
//   The enclosing level drives data_memory reset_n from ~reset.
//   data_memory reads combinationally: dmem_read_data is valid in the same
//   cycle as dmem_read_enable.
//
//   Optional build macro: LSU_BOUNDS_CHECK_EN. When it is defined, a request
//   whose word index (addr>>2) is >= DMEM_WORDS returns an error and touches
//   no memory. When it is undefined, the word index wraps modulo DMEM_WORDS.
//
//   Ports
//     clk, reset              clock; asynchronous active-high reset
//     req_valid/req_ready     request handshake (ready only in IDLE)
//     req_store, req_funct3   operation (RV32I funct3 encoding)
//     req_addr, req_wdata     byte address, store data
//     resp_valid/resp_ready   response handshake
//     resp_rdata, resp_error  extended load data (0 for stores/errors), error flag
//     dmem_*                  word index, read/write strobes, write data, read data

// One byte lane of the SB/SH merge. The lane takes the new store byte when the
// access covers it. Otherwise it keeps the byte read from memory.
module lsu_byte_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  lane_sel,   // latched addr[1:0]
  input  logic        is_half,    // 1 = SH, 0 = SB
  input  logic [15:0] st_data,
  input  logic [7:0]  old_byte,
  output logic [7:0]  new_byte
);
  localparam logic [1:0] LANE_ID = 2'(LANE);

  logic hit;

  always_comb begin
    hit      = is_half ? (lane_sel[1] == LANE_ID[1]) : (lane_sel == LANE_ID);
    new_byte = old_byte;
    if (hit) new_byte = (is_half && LANE_ID[0]) ? st_data[15:8] : st_data[7:0];
  end
endmodule

module load_store_unit #(
  parameter int DMEM_WORDS = 1024,
  parameter int WORD_IDX_W = $clog2(DMEM_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] dmem_addr,
  output logic        dmem_read_enable,
  output logic        dmem_write_enable,
  output logic [31:0] dmem_write_data,
  input  logic [31:0] dmem_read_data
);
  typedef enum logic [2:0] {
    IDLE, LOAD, STORE_W, RMW_RD, RMW_WR, RESP
  } state_e;

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [15:0] st_data_q, st_data_d;

  // Request decode. This is only meaningful while req_valid is high in IDLE.
  logic [WORD_IDX_W-1:0] req_idx;
  logic                  misaligned, illegal, out_of_range, req_err;

  // Only the index bits reach data_memory. Without the bounds check, the
  // upper address bits are dropped on purpose.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:WORD_IDX_W+2];

  always_comb begin
    req_idx    = req_addr[WORD_IDX_W+1:2];
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    if (req_store) illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else           illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
`ifdef LSU_BOUNDS_CHECK_EN
    out_of_range = (req_addr[31:2] >= 30'(DMEM_WORDS));
`else
    out_of_range = 1'b0;
`endif
    req_err = misaligned || illegal || out_of_range;
  end

  // Load extraction from the word returned in the LOAD cycle.
  logic [3:0][7:0] rd_bytes;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_result;

  always_comb begin
    rd_bytes = dmem_read_data;
    ld_byte  = rd_bytes[addr_lo_q];
    ld_half  = addr_lo_q[1] ? dmem_read_data[31:16] : dmem_read_data[15:0];
    case (funct3_q)
      3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_result = {24'h0, ld_byte};
      3'b101:  ld_result = {16'h0, ld_half};
      default: ld_result = dmem_read_data;
    endcase
  end

  // SB/SH merge: four byte lanes build the word written back in RMW_WR.
  logic [3:0][7:0] merged;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    lsu_byte_lane #(.LANE(g)) u_lane (
      .lane_sel (addr_lo_q),
      .is_half  (funct3_q[0]),
      .st_data  (st_data_q),
      .old_byte (dmem_read_data[8*g +: 8]),
      .new_byte (merged[g])
    );
  end

  // Next-state logic. The strobes and response fields are set up one edge
  // early so that every output comes straight from a flop.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_error_d = resp_error_q;
    dmem_addr_d  = dmem_addr_q;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    st_data_d    = st_data_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          funct3_d    = req_funct3;
          addr_lo_d   = req_addr[1:0];
          st_data_d   = req_wdata[15:0];
          dmem_addr_d = {{(32-WORD_IDX_W){1'b0}}, req_idx};
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = 32'h0;
          end else if (!req_store) begin
            state_d = LOAD;
            rd_en_d = 1'b1;
          end else if (req_funct3 == 3'b010) begin
            state_d   = STORE_W;
            wr_en_d   = 1'b1;
            wr_data_d = req_wdata;
          end else begin
            state_d = RMW_RD;
            rd_en_d = 1'b1;
          end
        end
      end
      LOAD: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_error_d = 1'b0;
        resp_rdata_d = ld_result;
      end
      STORE_W: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_error_d = 1'b0;
        resp_rdata_d = 32'h0;
      end
      RMW_RD: begin
        state_d   = RMW_WR;
        wr_en_d   = 1'b1;
        wr_data_d = merged;
      end
      RMW_WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_error_d = 1'b0;
        resp_rdata_d = 32'h0;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // Asynchronous reset clears the write strobe at once. A reset in RMW_WR
  // therefore never commits the merged word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_error_q <= 1'b0;
      dmem_addr_q  <= 32'h0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= 32'h0;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
      st_data_q    <= 16'h0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      dmem_addr_q  <= dmem_addr_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      st_data_q    <= st_data_d;
    end
  end

  assign req_ready         = req_ready_q;
  assign resp_valid        = resp_valid_q;
  assign resp_rdata        = resp_rdata_q;
  assign resp_error        = resp_error_q;
  assign dmem_addr         = dmem_addr_q;
  assign dmem_read_enable  = rd_en_q;
  assign dmem_write_enable = wr_en_q;
  assign dmem_write_data   = wr_data_q;
endmodule
